// File: rtl/bus_arbiter.sv
// Two-master (fetch m0, load/store m1) to one-bus arbiter with a response watchdog.
// Define ROUND_ROBIN_EN to break simultaneous requests in favour of the master not granted last.
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_read,
  input  logic [31:0] m0_address,
  output logic [31:0] m0_read_data,
  output logic        m0_response,
  output logic        m0_error,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_write_data,
  output logic [31:0] m1_read_data,
  output logic        m1_response,
  output logic        m1_error,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data,
  input  logic        bus_response
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_next;
  logic                 grant_m1;
  logic                 op_write;
  logic                 timed_out;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_m0_q;
  logic [31:0]          rdata_m1_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 m1_req;
  logic                 any_req;
  logic                 sel_m1;
  logic                 timeout_hit;

  assign m1_req  = m1_read | m1_write;
  assign any_req = m0_read | m1_req;
  assign cnt_inc = cnt + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_WIDTH'(TIMEOUT_CYCLES));

`ifdef ROUND_ROBIN_EN
  logic last_m1;

  // On a tie the master that did not win last time gets the bus.
  assign sel_m1 = m1_req && (!m0_read || !last_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_m1 <= 1'b0;
    else if (state == IDLE && any_req)
      last_m1 <= sel_m1;
  end
`else
  assign sel_m1 = m1_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    bus_read    = 1'b0;
    bus_write   = 1'b0;
    m0_response = 1'b0;
    m0_error    = 1'b0;
    m1_response = 1'b0;
    m1_error    = 1'b0;
    case (state)
      IDLE: if (any_req) state_next = BUSY;
      BUSY: begin
        bus_read  = !op_write;
        bus_write = op_write;
        if (bus_response || timeout_hit) state_next = DONE;
      end
      DONE: begin
        m0_response = !grant_m1;
        m0_error    = !grant_m1 && timed_out;
        m1_response = grant_m1;
        m1_error    = grant_m1 && timed_out;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_m1   <= 1'b0;
      op_write   <= 1'b0;
      timed_out  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_m0_q <= '0;
      rdata_m1_q <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant_m1  <= sel_m1;
          op_write  <= sel_m1 && m1_write;
          addr_q    <= sel_m1 ? m1_address : m0_address;
          wdata_q   <= sel_m1 ? m1_write_data : '0;
          cnt       <= '0;
          timed_out <= 1'b0;
        end
        BUSY: begin
          cnt <= cnt_inc;
          // A response in the timeout cycle takes precedence over the error.
          if (bus_response) begin
            if (grant_m1) rdata_m1_q <= op_write ? '0 : bus_read_data;
            else          rdata_m0_q <= op_write ? '0 : bus_read_data;
          end else if (timeout_hit) begin
            timed_out <= 1'b1;
            if (grant_m1) rdata_m1_q <= '0;
            else          rdata_m0_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_address    = addr_q;
  assign bus_write_data = wdata_q;
  assign m0_read_data   = rdata_m0_q;
  assign m1_read_data   = rdata_m1_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a behavioural slave with programmable latency,
// expected completions queued at issue time and compared when a response pulse appears.
module tb_bus_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_read;
  logic [31:0] m0_address;
  logic [31:0] m0_read_data;
  logic        m0_response, m0_error;
  logic        m1_read, m1_write;
  logic [31:0] m1_address, m1_write_data;
  logic [31:0] m1_read_data;
  logic        m1_response, m1_error;
  logic        bus_read, bus_write;
  logic [31:0] bus_address, bus_write_data;
  logic [31:0] bus_read_data = '0;
  logic        bus_response = 1'b0;

  bus_arbiter #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_read(m0_read), .m0_address(m0_address), .m0_read_data(m0_read_data),
    .m0_response(m0_response), .m0_error(m0_error),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_write_data(m1_write_data), .m1_read_data(m1_read_data),
    .m1_response(m1_response), .m1_error(m1_error),
    .bus_read(bus_read), .bus_write(bus_write), .bus_address(bus_address),
    .bus_write_data(bus_write_data), .bus_read_data(bus_read_data),
    .bus_response(bus_response)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          m1;
    logic [31:0] data;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // Slave: answers slave_delay cycles after the strobe starts (negative = never).
  int          slave_delay = -1;
  logic [31:0] slave_data = '0;
  bit          stray = 1'b0;
  int          busy_cnt = 0;
  int          last_len = 0;
  int          unstable = 0;
  logic [31:0] first_addr, first_wdata;
  logic        first_write;
  bit          resp;

  always @(negedge clk) begin
    if (bus_read || bus_write) begin
      busy_cnt = busy_cnt + 1;
      if (busy_cnt == 1) begin
        first_addr  = bus_address;
        first_wdata = bus_write_data;
        first_write = bus_write;
      end else if (bus_address != first_addr || bus_write_data != first_wdata ||
                   bus_write != first_write) begin
        unstable = unstable + 1;
      end
      last_len = busy_cnt;
    end else begin
      busy_cnt = 0;
    end
    resp = (slave_delay >= 0) && (bus_read || bus_write) && (busy_cnt == slave_delay + 1);
    bus_response  = stray || resp;
    bus_read_data = resp ? (slave_data ^ bus_address) : 32'hFFFF_FFFF;
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (rst_n && (m0_response || m1_response)) begin
      if (sb.size() == 0) begin
        check("spurious_resp", {m1_response, m0_response}, 2'b00);
      end else begin
        e = sb.pop_front();
        check("resp_port", {m1_response, m0_response}, e.m1 ? 2'b10 : 2'b01);
        check("resp_data", e.m1 ? m1_read_data : m0_read_data, e.data);
        check("resp_error", e.m1 ? m1_error : m0_error, e.err);
        check("resp_cycle", cyc, e.cyc);
      end
    end
    if (rst_n && ((m0_error && !m0_response) || (m1_error && !m1_response)))
      check("error_without_resp", {m1_error, m0_error}, 2'b00);
  end

  bit model_last_m1 = 1'b0;

  task automatic xfer(input bit use_m1, input bit wr, input bit both, input logic [31:0] addr,
                      input logic [31:0] wdata, input int k, input logic [31:0] rdata,
                      input bit drop_early);
    bit   tmo;
    bit   got;
    exp_t x;
    tmo = (k < 0) || (k >= T);
    slave_delay = k;
    slave_data  = rdata ^ addr;
    unstable    = 0;
    x.m1   = use_m1;
    x.data = (tmo || wr) ? 32'h0 : rdata;
    x.err  = tmo;
    x.cyc  = tmo ? cyc + 1 + T : cyc + 2 + k;
    sb.push_back(x);
    if (use_m1) begin
      m1_read = !wr || both; m1_write = wr; m1_address = addr; m1_write_data = wdata;
    end else begin
      m0_read = 1'b1; m0_address = addr;
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (use_m1 ? m1_response : m0_response) got = 1;
      else if (drop_early && i == 0) begin
        #1 m0_read = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
      end
    end
    if (!got) check("resp_wait", 1'b0, 1'b1);
    #1 m0_read = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    model_last_m1 = use_m1;
    check("strobe_len", last_len, tmo ? T : k + 1);
    check("bus_stable", unstable, 0);
    check("bus_addr", first_addr, addr);
    check("bus_op", first_write, wr);
    if (wr) check("bus_wdata", first_wdata, wdata);
    @(negedge clk);
    #1;
  endtask

  task automatic tie3(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] s);
    int   seen;
    bit   w;
    exp_t x;
    slave_delay = 0;
    slave_data  = s;
    for (int i = 0; i < 3; i++) begin
`ifdef ROUND_ROBIN_EN
      w = !model_last_m1;
`else
      w = 1'b1;
`endif
      model_last_m1 = w;
      x.m1 = w; x.data = s ^ (w ? a1 : a0); x.err = 1'b0; x.cyc = cyc + 2 + 3 * i;
      sb.push_back(x);
    end
    m0_read = 1'b1; m0_address = a0;
    m1_read = 1'b1; m1_write = 1'b0; m1_address = a1; m1_write_data = '0;
    seen = 0;
    for (int i = 0; i < 30 && seen < 3; i++) begin
      @(negedge clk);
      if (m0_response || m1_response) seen++;
    end
    check("tie_resp_count", seen, 3);
    #1 m0_read = 1'b0; m1_read = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0;
    m0_read = 1'b0; m0_address = '0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_write_data = '0;
    repeat (3) @(negedge clk);
    check("reset_strobes", {bus_read, bus_write, m0_response, m0_error, m1_response, m1_error}, '0);
    check("reset_bus", {bus_address, bus_write_data}, '0);
    check("reset_rdata", {m0_read_data, m1_read_data}, '0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;

    xfer(0, 0, 0, 32'h0000_0100, '0, 0, 32'hDEAD_BEEF, 0);
    check("m0_rdata_hold", m0_read_data, 32'hDEAD_BEEF);
    xfer(1, 1, 0, 32'h4000_0004, 32'h1234_5678, 3, 32'h0, 0);
    check("m0_untouched", m0_read_data, 32'hDEAD_BEEF);
    tie3(32'h0000_0200, 32'h8000_0010, 32'h5A5A_0F0F);
    xfer(1, 0, 0, 32'h2000_0000, '0, -1, 32'h1111_1111, 0);
    xfer(1, 0, 0, 32'h2000_0008, '0, T - 1, 32'hCAFE_F00D, 0);
    xfer(1, 1, 1, 32'h3000_0000, 32'hA5A5_5A5A, 1, 32'h7777_7777, 0);
    xfer(0, 0, 0, 32'h0000_0300, '0, 2, 32'h0BAD_CAFE, 1);

    // Stray slave response while idle must neither complete nor corrupt read data.
    stray = 1'b1;
    repeat (3) @(negedge clk);
    #1 stray = 1'b0;
    @(negedge clk);
    check("stray_rdata_hold", m0_read_data, 32'h0BAD_CAFE);

    // Reset during BUSY.
    #1 slave_delay = -1;
    m1_read = 1'b1; m1_address = 32'h5000_0000;
    repeat (2) @(negedge clk);
    check("busy_before_reset", bus_read, 1'b1);
    #1 rst_n = 1'b0;
    #1 check("async_reset_strobe", {bus_read, bus_write}, 2'b00);
    m1_read = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    model_last_m1 = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    xfer(0, 0, 0, 32'h0000_0400, '0, 1, 32'h600D_D00D, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
